// File: rtl/pam4_pkg.sv
// Shared PAM4 definitions: state enum, default level constants and the symbol-to-level mapping.
// Define PAM4_TX_GRAY_EN to switch data and training symbols from binary to Gray mapping.
package pam4_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        TRAIN = 2'd2
    } pam4_state_e;

    localparam int         DEFAULT_SEPARATION = 56;
    localparam int         LEVEL_L0           = -(DEFAULT_SEPARATION / 2) - DEFAULT_SEPARATION;
    localparam int         LEVEL_L1           = -(DEFAULT_SEPARATION / 2);
    localparam int         LEVEL_L2           = DEFAULT_SEPARATION / 2;
    localparam int         LEVEL_L3           = (DEFAULT_SEPARATION / 2) + DEFAULT_SEPARATION;
    localparam logic [6:0] PRBS7_SEED         = 7'h7F;

    // Levels are evenly spaced by sep, so the level index scales a single step.
    function automatic int pam4_level(input logic [1:0] sym, input int sep);
        logic [1:0] idx;
`ifdef PAM4_TX_GRAY_EN
        idx = {sym[1], sym[1] ^ sym[0]};
`else
        idx = sym;
`endif
        return -(sep / 2) - sep + int'(idx) * sep;
    endfunction

endpackage

// File: rtl/pam4_prbs7.sv
// PRBS7 (x^7 + x^6 + 1) generator with seed load and a two-step advance per enable.
// Exposes only the top two bits, which form one PAM4 training symbol.
module pam4_prbs7
    import pam4_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       seed_load_i,
    input  logic       adv_i,
    output logic [1:0] sym_o
);

    logic [6:0] lfsr_q, lfsr_d;
    logic [6:0] step1;

    always_comb begin
        step1  = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        lfsr_d = lfsr_q;
        if (seed_load_i) begin
            lfsr_d = PRBS7_SEED;
        end else if (adv_i) begin
            lfsr_d = {step1[5:0], step1[6] ^ step1[5]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            lfsr_q <= PRBS7_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign sym_o = lfsr_q[6:5];

endmodule

// File: rtl/pam4_tx.sv
// PAM4 transmitter: serialises bytes into 4 symbols, or emits a PRBS7 training burst,
// adding half of the previous level as ISI. PAM4_TX_GRAY_EN selects Gray symbol mapping.
module pam4_tx
    import pam4_pkg::*;
#(
    parameter int SIGNAL_RESOLUTION = 8,
    parameter int SYMBOL_SEPERATION = 56,
    parameter int TRAIN_SYMBOLS     = 64
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [7:0]                          data_in,
    input  logic                                data_in_valid,
    output logic                                data_in_ready,
    input  logic                                train_start,
    output logic signed [SIGNAL_RESOLUTION-1:0] signal_out,
    output logic                                signal_out_valid,
    output logic signed [SIGNAL_RESOLUTION-1:0] train_data,
    output logic                                train_data_valid,
    output logic                                busy
);

    localparam int TCW     = $clog2(TRAIN_SYMBOLS + 1);
    localparam int OUT_MAX = (1 << (SIGNAL_RESOLUTION - 1)) - 1;
    localparam int OUT_MIN = -(1 << (SIGNAL_RESOLUTION - 1));

    typedef logic signed [SIGNAL_RESOLUTION-1:0] sample_t;

    pam4_state_e    state_q, state_d;
    logic [2:0]     sym_cnt_q, sym_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic [TCW-1:0] train_cnt_q, train_cnt_d;
    sample_t        hist_q, hist_d;
    sample_t        sig_q, sig_d;
    logic           sig_valid_q, sig_valid_d;
    sample_t        trn_q, trn_d;
    logic           trn_valid_q, trn_valid_d;

    logic           seed_load;
    logic           lfsr_adv;
    logic [1:0]     prbs_sym;
    logic           emit;
    logic [1:0]     sym;
    logic           accept;
    int             level;
    int             isi_sum;

    pam4_prbs7 u_prbs7 (
        .clk        (clk),
        .rstn       (rstn),
        .seed_load_i(seed_load),
        .adv_i      (lfsr_adv),
        .sym_o      (prbs_sym)
    );

    assign data_in_ready = (state_q != TRAIN) && (sym_cnt_q <= 3'd1)
                           && !(state_q == IDLE && train_start);
    assign accept        = data_in_valid && data_in_ready;
    assign busy          = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        sym_cnt_d   = sym_cnt_q;
        shift_d     = shift_q;
        train_cnt_d = train_cnt_q;
        seed_load   = 1'b0;
        lfsr_adv    = 1'b0;
        emit        = 1'b0;
        sym         = 2'b00;

        unique case (state_q)
            IDLE: begin
                if (train_start) begin
                    state_d     = TRAIN;
                    seed_load   = 1'b1;
                    train_cnt_d = TCW'(TRAIN_SYMBOLS);
                end else if (accept) begin
                    state_d   = DATA;
                    shift_d   = data_in;
                    sym_cnt_d = 3'd4;
                end
            end
            DATA: begin
                emit      = 1'b1;
                sym       = shift_q[7:6];
                shift_d   = {shift_q[5:0], 2'b00};
                sym_cnt_d = sym_cnt_q - 3'd1;
                // A new byte may load on the same edge the last symbol leaves.
                if (accept) begin
                    shift_d   = data_in;
                    sym_cnt_d = 3'd4;
                end else if (sym_cnt_q == 3'd1) begin
                    state_d = IDLE;
                end
            end
            TRAIN: begin
                emit        = 1'b1;
                sym         = prbs_sym;
                lfsr_adv    = 1'b1;
                train_cnt_d = train_cnt_q - TCW'(1);
                if (train_cnt_q == TCW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        level       = 0;
        isi_sum     = 0;
        hist_d      = '0;
        sig_d       = '0;
        sig_valid_d = 1'b0;
        trn_d       = '0;
        trn_valid_d = 1'b0;
        if (emit) begin
            level       = pam4_level(sym, SYMBOL_SEPERATION);
            isi_sum     = level + (int'(hist_q) >>> 1);
            hist_d      = sample_t'(level);
            sig_valid_d = 1'b1;
            if (isi_sum > OUT_MAX) begin
                sig_d = sample_t'(OUT_MAX);
            end else if (isi_sum < OUT_MIN) begin
                sig_d = sample_t'(OUT_MIN);
            end else begin
                sig_d = sample_t'(isi_sum);
            end
            if (state_q == TRAIN) begin
                trn_d       = sample_t'(level);
                trn_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            sym_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            train_cnt_q <= '0;
            hist_q      <= '0;
            sig_q       <= '0;
            sig_valid_q <= 1'b0;
            trn_q       <= '0;
            trn_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sym_cnt_q   <= sym_cnt_d;
            shift_q     <= shift_d;
            train_cnt_q <= train_cnt_d;
            hist_q      <= hist_d;
            sig_q       <= sig_d;
            sig_valid_q <= sig_valid_d;
            trn_q       <= trn_d;
            trn_valid_q <= trn_valid_d;
        end
    end

    assign signal_out       = sig_q;
    assign signal_out_valid = sig_valid_q;
    assign train_data       = trn_q;
    assign train_data_valid = trn_valid_q;

endmodule

// File: tb/tb_pam4_tx.sv
// Self-checking bench for pam4_tx: queue-based symbol model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pam4_tx;

    localparam int RES    = 8;
    localparam int SEP    = 56;
    localparam int NTRAIN = 64;

    logic              clk = 1'b0;
    logic              rstn;
    logic [7:0]        data_in;
    logic              data_in_valid;
    logic              data_in_ready;
    logic              train_start;
    logic signed [7:0] signal_out;
    logic              signal_out_valid;
    logic signed [7:0] train_data;
    logic              train_data_valid;
    logic              busy;

    pam4_tx #(
        .SIGNAL_RESOLUTION(RES),
        .SYMBOL_SEPERATION(SEP),
        .TRAIN_SYMBOLS    (NTRAIN)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .data_in         (data_in),
        .data_in_valid   (data_in_valid),
        .data_in_ready   (data_in_ready),
        .train_start     (train_start),
        .signal_out      (signal_out),
        .signal_out_valid(signal_out_valid),
        .train_data      (train_data),
        .train_data_valid(train_data_valid),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;
    int cycleCnt   = 0;

    int symQ[$];
    int trainLeft     = 0;
    int lfsrM         = 7'h7F;
    int prevLvl       = 0;
    int expOut        = 0;
    int expTrain      = 0;
    bit expValid      = 1'b0;
    bit expTrainValid = 1'b0;
    bit modelLive     = 1'b0;

    int capQ[$];
    int capCycle[$];
    int trainCount = 0;
    int firstTrain = 0;

    function automatic int modelLevel(input int s);
        int rank;
`ifdef PAM4_TX_GRAY_EN
        int grayRank[4] = '{0, 1, 3, 2};
        rank = grayRank[s];
`else
        rank = s;
`endif
        return -(SEP / 2) - SEP + rank * SEP;
    endfunction

    function automatic int sat(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic int prbsStep(input int l);
        int fb;
        fb = ((l >> 6) ^ (l >> 5)) & 1;
        return ((l << 1) | fb) & 8'h7F;
    endfunction

    function automatic bit modelIdle();
        return (trainLeft == 0) && (symQ.size() == 0);
    endfunction

    function automatic bit modelReady(input logic ts);
        return (trainLeft == 0) && (symQ.size() <= 1) && !(modelIdle() && ts);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCnt);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic t, input logic r);
        @(posedge clk);
        #1;
        data_in_valid = v;
        data_in       = d;
        train_start   = t;
        rstn          = r;
    endtask

    // Reference model: advances one symbol per cycle from a pending-symbol queue or a training burst.
    always @(posedge clk) begin : model
        int  s;
        int  lvl;
        bit  have;
        bit  training;
        bit  idle;
        bit  ready;
        cycleCnt++;
        if (!rstn) begin
            symQ.delete();
            trainLeft     = 0;
            lfsrM         = 7'h7F;
            prevLvl       = 0;
            expOut        = 0;
            expValid      = 1'b0;
            expTrain      = 0;
            expTrainValid = 1'b0;
            modelLive     = 1'b1;
        end else if (modelLive) begin
            idle     = modelIdle();
            ready    = modelReady(train_start);
            have     = 1'b0;
            training = 1'b0;
            s        = 0;
            if (trainLeft > 0) begin
                s        = (lfsrM >> 5) & 3;
                have     = 1'b1;
                training = 1'b1;
                lfsrM    = prbsStep(prbsStep(lfsrM));
                trainLeft--;
            end else if (symQ.size() > 0) begin
                s    = symQ.pop_front();
                have = 1'b1;
            end
            if (data_in_valid && ready) begin
                for (int i = 0; i < 4; i++) symQ.push_back((int'(data_in) >> (6 - 2 * i)) & 3);
            end
            if (idle && train_start) begin
                trainLeft = NTRAIN;
                lfsrM     = 7'h7F;
            end
            if (have) begin
                lvl           = modelLevel(s);
                expOut        = sat(lvl + (prevLvl >>> 1));
                expValid      = 1'b1;
                prevLvl       = lvl;
                expTrain      = training ? lvl : 0;
                expTrainValid = training;
            end else begin
                expOut        = 0;
                expValid      = 1'b0;
                expTrain      = 0;
                expTrainValid = 1'b0;
                prevLvl       = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (modelLive) begin
            checkOutput("data_in_ready", int'(data_in_ready), int'(modelReady(train_start)));
            checkOutput("busy", int'(busy), int'(!modelIdle()));
            checkOutput("signal_out_valid", int'(signal_out_valid), int'(expValid));
            checkOutput("signal_out", int'(signal_out), expOut);
            checkOutput("train_data_valid", int'(train_data_valid), int'(expTrainValid));
            checkOutput("train_data", int'(train_data), expTrain);
        end
        if (signal_out_valid) begin
            capQ.push_back(int'(signal_out));
            capCycle.push_back(cycleCnt);
        end
        if (train_data_valid) begin
            if (trainCount == 0) firstTrain = int'(train_data);
            trainCount++;
        end
    end

    initial begin
        int expE4[4];
        int expFF00[8];
        int expFirstTrain;
        int acceptCycle;
        int readyHigh;
`ifdef PAM4_TX_GRAY_EN
        expE4         = '{28, 98, 14, -98};
        expFirstTrain = 28;
`else
        expE4         = '{84, 70, -14, -98};
        expFirstTrain = 84;
`endif
        expFF00 = '{84, 126, 126, 126, -42, -126, -126, -126};

        rstn          = 1'b0;
        data_in       = 8'h00;
        data_in_valid = 1'b0;
        train_start   = 1'b0;

        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("reset_signal_out", int'(signal_out), 0);
        checkOutput("reset_out_valid", int'(signal_out_valid), 0);
        checkOutput("reset_train_valid", int'(train_data_valid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_ready", int'(data_in_ready), 1);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        capQ.delete();
        capCycle.delete();
        applyStimulus(1'b1, 8'hE4, 1'b0, 1'b1);
        acceptCycle = cycleCnt;
        repeat (8) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("e4_count", capQ.size(), 4);
        for (int i = 0; i < 4; i++) checkOutput("e4_sample", (i < capQ.size()) ? capQ[i] : 9999, expE4[i]);
        checkOutput("e4_latency", (capCycle.size() > 0) ? capCycle[0] - acceptCycle : -1, 2);

        capQ.delete();
        capCycle.delete();
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1);
        repeat (4) applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
        repeat (12) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("b2b_count", capQ.size(), 8);
        for (int i = 0; i < 8; i++) checkOutput("b2b_sample", (i < capQ.size()) ? capQ[i] : 9999, expFF00[i]);
        checkOutput("b2b_gapless", (capCycle.size() == 8) ? capCycle[7] - capCycle[0] : -1, 7);

        trainCount = 0;
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("train_start_ready", int'(data_in_ready), 0);
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b1);
        readyHigh = 0;
        for (int i = 0; i < NTRAIN; i++) begin
            @(negedge clk);
            if (data_in_ready) readyHigh++;
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("train_end_ready", int'(data_in_ready), 1);
        checkOutput("train_end_busy", int'(busy), 0);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("train_count", trainCount, NTRAIN);
        checkOutput("train_first", firstTrain, expFirstTrain);
        checkOutput("train_ready_high", readyHigh, 0);

        capQ.delete();
        capCycle.delete();
        applyStimulus(1'b1, 8'hE4, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("midreset_signal_out", int'(signal_out), 0);
        checkOutput("midreset_out_valid", int'(signal_out_valid), 0);
        repeat (10) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("midreset_sample_count", capQ.size(), 2);

        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 9) < 7,
                          8'($urandom),
                          $urandom_range(0, 59) == 0,
                          $urandom_range(0, 499) != 0);
        end
        repeat (5) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/pam4_tx.md
PAM4_TX -- requirements
Module: pam4_tx

Interface
REQ-001 SHALL have parameter SIGNAL_RESOLUTION, default 8: width of signed output levels.
REQ-002 SHALL have parameter SYMBOL_SEPERATION, default 56: spacing between adjacent PAM4 levels.
REQ-003 SHALL have parameter TRAIN_SYMBOLS, default 64: training-burst length in symbols.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port data_in  input  8  payload byte, sent as 4 symbols, bits [7:6] first.
REQ-007 SHALL have port data_in_valid  input  1  data_in offered.
REQ-008 SHALL have port data_in_ready  output  1  byte accepted on an edge where valid && ready.
REQ-009 SHALL have port train_start  input  1  single-cycle training request.
REQ-010 SHALL have port signal_out  output  SIGNAL_RESOLUTION signed  channel sample: level plus ISI.
REQ-011 SHALL have port signal_out_valid  output  1  signal_out carries a symbol.
REQ-012 SHALL have port train_data  output  SIGNAL_RESOLUTION signed  ideal training level, no ISI.
REQ-013 SHALL have port train_data_valid  output  1  train_data valid.
REQ-014 SHALL have port busy  output  1  state != IDLE.

Function
REQ-015 SHALL map a 2-bit symbol to levels L0=-(S/2)-S, L1=-(S/2), L2=+(S/2), L3=+(S/2)+S (S=SYMBOL_SEPERATION; default -84,-28,+28,+84); binary mapping 00->L0, 01->L1, 10->L2, 11->L3.
REQ-016 SHALL use FSM states IDLE, DATA, TRAIN; emit at most one symbol per cycle.
REQ-017 SHALL keep sym_cnt (0..4) of symbols remaining; data_in_ready = (state != TRAIN) && (sym_cnt <= 1) && !(state==IDLE && train_start).
REQ-018 SHALL, on acceptance, load the byte into a shift register and set sym_cnt=4 (the last symbol of the previous byte still emits on the same edge), giving gapless back-to-back bytes.
REQ-019 SHALL register outputs: symbol 0 of a byte accepted at edge k appears on signal_out after edge k+1.
REQ-020 SHALL compute signal_out = level[n] + (level[n-1] >>> 1), saturating to the SIGNAL_RESOLUTION signed range; level[n-1] is 0 if the previous cycle emitted no symbol.
REQ-021 SHALL, in cycles without a symbol, drive signal_out=0, signal_out_valid=0, and clear the ISI history.
REQ-022 SHALL go IDLE->DATA on acceptance, and DATA->IDLE when sym_cnt reaches 0 with no new acceptance.
REQ-023 SHALL go IDLE->TRAIN on train_start; train_start wins over a simultaneous data_in_valid; train_start in DATA or TRAIN is ignored and not stored.
REQ-024 SHALL, in TRAIN, reseed PRBS7 (x^7+x^6+1) to 7'h7F on entry, emit symbol {lfsr[6],lfsr[5]}, and advance the LFSR 2 steps per symbol, for TRAIN_SYMBOLS consecutive cycles, then return to IDLE.
REQ-025 SHALL, in TRAIN, drive train_data = level and train_data_valid=1 in the same cycle as the matching signal_out; train_data_valid=0 otherwise.

Reset
REQ-026 SHALL, on rstn low, set all outputs to 0 except data_in_ready=1, state=IDLE, sym_cnt=0, ISI history=0, LFSR=7'h7F.
REQ-027 SHALL, on reset during DATA or TRAIN, discard the remaining symbols; no symbol emits after reset deasserts until a new acceptance or train_start.

Configuration
REQ-028 SHALL, with PAM4_TX_GRAY_EN defined, use Gray mapping 00->L0, 01->L1, 11->L2, 10->L3 for data and training; without it, use the binary mapping of REQ-015.

Structure
REQ-029 SHALL place level constants, the state enum and the symbol-to-level mapping function in a shared package pam4_pkg, also used by the receiver.
REQ-030 SHALL implement the LFSR as sub-module pam4_prbs7 (seed load, 2-step advance enable).

Verification
REQ-031 SHALL cover reset: rstn low 3 cycles -> signal_out=0, both valids 0, busy=0, data_in_ready=1.
REQ-032 SHALL cover single byte 0xE4 (binary) -> signal_out 84, 70, -14, -98 on 4 consecutive valid cycles, first after 2nd edge post-accept, then valid=0.
REQ-033 SHALL cover back-to-back 0xFF then 0x00, valid held -> 8 gapless samples 84,126,126,126,-42,-126,-126,-126.
REQ-034 SHALL cover train_start in IDLE, data_in_valid=1 same cycle -> 64 cycles train_data_valid=1, first train_data=+84, data_in_ready=0 throughout, then IDLE and ready=1.
REQ-035 SHALL cover PAM4_TX_GRAY_EN with byte 0xE4 -> signal_out 28, 98, 14, -98.
REQ-036 SHALL cover rstn low after 2 symbols of 0xE4 -> outputs 0 next cycle; no further valid samples.
